// File: rtl/mrd_fsm_source_if.sv
// rtl/mrd_fsm_source_if.sv - bank read port and output sample stream of the source reader
// Array entry 6-k belongs to bank k, matching the rden bit order (bit 6 = bank 0).
interface mrd_fsm_source_if #(
    parameter int wADDR = 8,
    parameter int wDATA = 30
);
    logic [6:0]             rden;
    logic [6:0][wADDR-1:0]  rdaddr;
    logic [6:0][wDATA-1:0]  rddata;
    logic [wDATA-1:0]       out_data;
    logic                   out_valid;
    logic                   out_sop;
    logic                   out_eop;

    modport master (
        output rden, rdaddr, out_data, out_valid, out_sop, out_eop,
        input  rddata
    );

    modport slave (
        input  rden, rdaddr, out_data, out_valid, out_sop, out_eop,
        output rddata
    );
endinterface

// File: rtl/mrd_fsm_source.sv
// rtl/mrd_fsm_source.sv - reads a frame back from the 7 banks as a framed sample stream
// Reads round-robin bank 0..6; a 2-deep bank/tag delay line aligns with the RAM latency.
module mrd_fsm_source #(
    parameter int wADDR = 8,
    parameter int wDATA = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          fsm_i,
    input  logic                start_i,
    input  logic [11:0]         len_i,
    mrd_fsm_source_if.master    bus,
    output logic                source_3_4_o,
    output logic                done_o
);
    localparam logic [2:0]  FSM_SOURCE = 3'd5;
    localparam logic [31:0] MAX_LEN    = 32'(7 * (2 ** wADDR));

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [2:0]         bank_q, bank_d;
    logic [wADDR-1:0]   addr_q, addr_d;
    logic [11:0]        cnt_rd_q, cnt_rd_d;
    logic [11:0]        n_q, n_d;
    logic [11:0]        cnt_out_q, cnt_out_d;
    logic [2:0]         bank1_q, bank2_q;
    logic               v1_q, v1_d, s1_q, s1_d, e1_q, e1_d;
    logic               v2_q, v2_d, s2_q, s2_d, e2_q, e2_d;
    logic [wDATA-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic               s34_q, s34_d;
    logic               done_q, done_d;

    logic               len_ok;
    logic               abort;
    logic               last_rd;
    logic [11:0]        thresh;

    assign len_ok  = (len_i != 12'd0) && ({20'd0, len_i} <= MAX_LEN);
    assign abort   = (state_q != IDLE) && (fsm_i != FSM_SOURCE);
    assign last_rd = (cnt_rd_q == n_q - 12'd1);
    assign thresh  = {2'b00, n_q[11:2]} + {1'b0, n_q[11:1]} - 12'd1;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        addr_d      = addr_q;
        cnt_rd_d    = cnt_rd_q;
        n_d         = n_q;
        cnt_out_d   = v2_q ? cnt_out_q + 12'd1 : cnt_out_q;
        v1_d        = 1'b0;
        s1_d        = 1'b0;
        e1_d        = 1'b0;
        v2_d        = v1_q;
        s2_d        = s1_q;
        e2_d        = e1_q;
        out_valid_d = v2_q;
        out_sop_d   = s2_q;
        out_eop_d   = e2_q;
        out_data_d  = v2_q ? bus.rddata[3'd6 - bank2_q] : out_data_q;
        s34_d       = v2_q && (cnt_out_q == thresh) && (cnt_out_q != 12'd0);
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && (fsm_i == FSM_SOURCE) && len_ok) begin
                    state_d   = READ;
                    n_d       = len_i;
                    bank_d    = 3'd0;
                    addr_d    = '0;
                    cnt_rd_d  = 12'd0;
                    cnt_out_d = 12'd0;
                end
            end
            READ: begin
                v1_d = 1'b1;
                s1_d = (cnt_rd_q == 12'd0);
                e1_d = last_rd;
                if (last_rd) begin
                    state_d = DRAIN;
                end else begin
                    cnt_rd_d = cnt_rd_q + 12'd1;
                    if (bank_q == 3'd6) begin
                        bank_d = 3'd0;
                        addr_d = addr_q + 1'b1;
                    end else begin
                        bank_d = bank_q + 3'd1;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && out_eop_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Leaving Source kills everything in flight so no eop/done can escape.
        if (abort) begin
            state_d     = IDLE;
            v1_d        = 1'b0;
            s1_d        = 1'b0;
            e1_d        = 1'b0;
            v2_d        = 1'b0;
            s2_d        = 1'b0;
            e2_d        = 1'b0;
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            s34_d       = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bank_q      <= 3'd0;
            addr_q      <= '0;
            cnt_rd_q    <= 12'd0;
            n_q         <= 12'd0;
            cnt_out_q   <= 12'd0;
            bank1_q     <= 3'd0;
            bank2_q     <= 3'd0;
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            e1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s2_q        <= 1'b0;
            e2_q        <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            s34_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            cnt_rd_q    <= cnt_rd_d;
            n_q         <= n_d;
            cnt_out_q   <= cnt_out_d;
            bank1_q     <= bank_q;
            bank2_q     <= bank1_q;
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            e1_q        <= e1_d;
            v2_q        <= v2_d;
            s2_q        <= s2_d;
            e2_q        <= e2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            s34_q       <= s34_d;
            done_q      <= done_d;
        end
    end

    assign bus.rden      = (state_q == READ) ? (7'b1000000 >> bank_q) : 7'd0;
    assign bus.rdaddr    = {7{addr_q}};
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign source_3_4_o  = s34_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_mrd_fsm_source.sv
// tb/tb_mrd_fsm_source.sv - directed bench for the 7-bank source reader
// Bank k at address a holds 16*a+k behind a 2-cycle read pipeline.
module tb_mrd_fsm_source;
    localparam int WA = 8;
    localparam int WD = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  fsm;
    logic        start;
    logic [11:0] len;
    logic        s34;
    logic        done;

    mrd_fsm_source_if #(.wADDR(WA), .wDATA(WD)) bus ();

    mrd_fsm_source #(.wADDR(WA), .wDATA(WD)) dut (
        .clk          (clk),
        .rst          (rst),
        .fsm_i        (fsm),
        .start_i      (start),
        .len_i        (len),
        .bus          (bus),
        .source_3_4_o (s34),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    logic [6:0][WD-1:0] stage1;
    always @(posedge clk) begin
        for (int k = 0; k < 7; k++) begin
            stage1[6-k]      <= WD'(16 * int'(bus.rdaddr[6-k]) + k);
            bus.rddata[6-k]  <= stage1[6-k];
        end
    end

    int nvec = 0;
    int nerr = 0;
    int n_s34;
    logic [6:0]    lg_rden [0:127];
    logic [WA-1:0] lg_addr [0:127];
    logic [WD-1:0] lg_data [0:127];
    logic          lg_sop  [0:127];
    logic          lg_eop  [0:127];
    logic          lg_s34  [0:127];
    logic          lg_done [0:127];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " rden"},   64'(bus.rden),      64'd0);
        chk({tag, " rdaddr"}, 64'(bus.rdaddr),    64'd0);
        chk({tag, " data"},   64'(bus.out_data),  64'd0);
        chk({tag, " valid"},  64'(bus.out_valid), 64'd0);
        chk({tag, " sop"},    64'(bus.out_sop),   64'd0);
        chk({tag, " eop"},    64'(bus.out_eop),   64'd0);
        chk({tag, " s34"},    64'(s34),           64'd0);
        chk({tag, " done"},   64'(done),          64'd0);
    endtask

    task automatic quiet(input int ncyc, input string tag);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("%s c%0d rden", tag, c),  64'(bus.rden),      64'd0);
            chk($sformatf("%s c%0d valid", tag, c), 64'(bus.out_valid), 64'd0);
            chk($sformatf("%s c%0d done", tag, c),  64'(done),          64'd0);
        end
    endtask

    task automatic launch(input int n);
        start = 1'b1;
        len   = 12'(n);
    endtask

    task automatic watch(input int n, input int ncyc, input int extra_c, input int abort_c);
        logic [6:0]          one;
        logic [6:0]          exp_rden;
        logic [WA-1:0]       ea;
        logic [6:0][WA-1:0]  exp_addr;
        logic                vld;
        logic                aborted;
        int                  j;
        int                  thr;
        one   = 7'b1000000;
        thr   = (n >> 2) + (n >> 1) - 1;
        n_s34 = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            aborted  = (abort_c > 0) && (c > abort_c);
            exp_rden = (!aborted && c <= n) ? (one >> ((c - 1) % 7)) : 7'd0;
            vld      = !aborted && (c >= 4) && (c <= n + 3);
            j        = c - 4;
            chk($sformatf("n%0d c%0d rden", n, c),  64'(bus.rden),      64'(exp_rden));
            chk($sformatf("n%0d c%0d valid", n, c), 64'(bus.out_valid), 64'(vld));
            chk($sformatf("n%0d c%0d sop", n, c),   64'(bus.out_sop),   64'(vld && c == 4));
            chk($sformatf("n%0d c%0d eop", n, c),   64'(bus.out_eop),   64'(vld && c == n + 3));
            chk($sformatf("n%0d c%0d done", n, c),  64'(done),          64'(!aborted && c == n + 4));
            chk($sformatf("n%0d c%0d s34", n, c),   64'(s34),           64'(vld && j == thr && j != 0));
            if (exp_rden != 7'd0) begin
                ea       = WA'((c - 1) / 7);
                exp_addr = {7{ea}};
                chk($sformatf("n%0d c%0d rdaddr", n, c), 64'(bus.rdaddr), 64'(exp_addr));
            end
            if (vld)
                chk($sformatf("n%0d c%0d data", n, c), 64'(bus.out_data), 64'(16 * (j / 7) + (j % 7)));
            lg_rden[c] = bus.rden;
            lg_addr[c] = bus.rdaddr[6];
            lg_data[c] = bus.out_data;
            lg_sop[c]  = bus.out_sop;
            lg_eop[c]  = bus.out_eop;
            lg_s34[c]  = s34;
            lg_done[c] = done;
            if (s34) n_s34++;
            if (c == extra_c) begin
                start = 1'b1;
                len   = 12'd3;
            end else begin
                start = 1'b0;
            end
            if (c == abort_c) fsm = 3'd1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        fsm   = 3'd5;
        start = 1'b0;
        len   = 12'd0;
        repeat (2) @(negedge clk);
        all_zero("reset");
        rst = 1'b0;
        quiet(3, "post_reset");

        launch(14);
        watch(14, 19, 0, 0);
        chk("n14 first data", 64'(lg_data[4]),  64'd0);
        chk("n14 data j6",    64'(lg_data[10]), 64'd6);
        chk("n14 data j7",    64'(lg_data[11]), 64'd16);
        chk("n14 last data",  64'(lg_data[17]), 64'd22);
        chk("n14 rden c7",    64'(lg_rden[7]),  64'b0000001);
        chk("n14 addr c8",    64'(lg_addr[8]),  64'd1);
        chk("n14 eop",        64'(lg_eop[17]),  64'd1);
        chk("n14 done",       64'(lg_done[18]), 64'd1);

        launch(10);
        watch(10, 15, 0, 0);
        chk("n10 last rden",  64'(lg_rden[10]), 64'b0010000);
        chk("n10 last addr",  64'(lg_addr[10]), 64'd1);
        chk("n10 s34",        64'(lg_s34[10]),  64'd1);
        chk("n10 s34 count",  64'(n_s34),       64'd1);
        chk("n10 eop",        64'(lg_eop[13]),  64'd1);
        chk("n10 done",       64'(lg_done[14]), 64'd1);

        fsm = 3'd1;
        launch(5);
        quiet(8, "ign_fsm1");
        fsm = 3'd5;
        launch(0);
        quiet(8, "ign_len0");
        launch(1793);
        quiet(8, "ign_len1793");

        launch(20);
        watch(20, 25, 5, 0);

        launch(100);
        watch(100, 30, 0, 20);
        fsm = 3'd5;
        quiet(2, "post_abort");
        launch(9);
        watch(9, 14, 0, 0);
        chk("n9 done", 64'(lg_done[13]), 64'd1);

        launch(1);
        watch(1, 6, 0, 0);
        chk("n1 sop",       64'(lg_sop[4]),  64'd1);
        chk("n1 eop",       64'(lg_eop[4]),  64'd1);
        chk("n1 done",      64'(lg_done[5]), 64'd1);
        chk("n1 no s34",    64'(n_s34),      64'd0);

        launch(3);
        watch(3, 8, 0, 0);
        chk("n3 done",      64'(lg_done[7]), 64'd1);
        chk("n3 no s34",    64'(n_s34),      64'd0);

        launch(50);
        watch(50, 8, 0, 0);
        rst = 1'b1;
        #1;
        all_zero("rst_mid");
        @(negedge clk);
        all_zero("rst_hold");
        rst = 1'b0;
        quiet(10, "post_rst");
        launch(7);
        watch(7, 12, 0, 0);
        chk("n7 data j6",   64'(lg_data[10]), 64'd6);
        chk("n7 done",      64'(lg_done[11]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mrd_fsm_source.md
# mrd_fsm_source

Source-side reader for the 7-bank mixed-radix DFT data memory. Once a frame has been written into the banks round-robin (bank 0..6, address advancing every 7 samples), this block reads it back in the same order. It emits the frame as a one-sample-per-cycle stream with sop/eop framing and reports completion to the top-level FSM while that FSM is in state Source (3'd5). It also raises a 3/4-frame pulse used to pre-arm the next sink pass.

## Interface
Parameters:
- wADDR, 8, per-bank address width; frame capacity is 7*2^wADDR samples.
- wDATA, 30, sample width (packed complex).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; asynchronous, active-high.
- fsm  in  3  top-level FSM state; Source = 3'd5.
- start  in  1  one-cycle frame-start request.
- len  in  12  frame length N in samples; sampled on an accepted start.
- rden  out  7  one-hot bank read enable; bit 6 = bank 0 ... bit 0 = bank 6.
- rdaddr  out  7 x wADDR  per-bank read address; all 7 entries are always equal.
- rddata  in  7 x wDATA  per-bank read data; fixed RAM read latency of 2 cycles.
- out_data  out  wDATA  output sample.
- out_valid  out  1  output sample valid; no backpressure.
- out_sop  out  1  first sample of the frame.
- out_eop  out  1  last sample of the frame.
- source_3_4  out  1  3/4-frame marker pulse.
- done  out  1  one-cycle frame-complete pulse.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE -> READ when all of the following hold; len is latched as N and bank_idx, addr and cnt_rd are cleared:
  - start=1;
  - fsm==3'd5;
  - 1 <= len <= 7*2^wADDR.
- A start that fails any of these conditions is ignored: no reads, no done. A start outside IDLE is also ignored.
- READ issues one read per cycle:
  - rden = one-hot(bank_idx), rdaddr[all] = addr;
  - bank_idx counts 0..6; on 6 it wraps to 0 and addr increments;
  - cnt_rd increments each read; the read with cnt_rd==N-1 is the last, then go to DRAIN.
- Outside READ, rden = 0 and rdaddr holds its value.
- bank_idx of each issued read travels down a 2-stage delay line. It selects the returning rddata bank, which is registered into out_data.
- A valid/sop/eop tag pipeline runs in parallel with the data; sop is tagged on the read with cnt_rd==0, eop on cnt_rd==N-1.
- DRAIN: when the eop-tagged sample leaves, pulse done for one cycle and return to IDLE.
- cnt_out (12-bit) counts output samples from 0. source_3_4 = 1 in the same cycle as the output sample with index cnt_out == N[11:2] + N[11:1] - 12'd1, using 12-bit modulo arithmetic. It is suppressed when cnt_out==0, so N<4 produces no pulse.
- Abort: if fsm != 3'd5 while in READ or DRAIN:
  - next cycle: state = IDLE, rden = 0;
  - valid/sop/eop tag pipeline cleared; out_valid = 0 from that cycle on;
  - no eop, no done.
- out_data is don't-care when out_valid = 0.

## Timing
- Start accepted at cycle T.
- First rden asserted at T+1; last at T+N.
- rddata for a read issued at cycle t is valid at t+2; out_* registered at t+3.
- out_valid high for cycles T+4 .. T+N+3 continuously; out_sop at T+4; out_eop at T+N+3.
- done at T+N+4; state is IDLE at T+N+4, so a new start is accepted from T+N+4.
- N=1: out_sop and out_eop in the same cycle.
- Reset asserted at any time: all outputs 0 immediately (rden, rdaddr, out_data, out_valid, out_sop, out_eop, source_3_4, done), state IDLE, all counters and pipelines 0. After release, the block waits for a new start.

## Test plan
- N=14, wADDR=8, bank k preloaded with value 16*addr+k; start at T:
  - rden = 1000000..0000001 at addr 0, then repeated at addr 1;
  - out_data = 0,1,..,6,16,..,22 at T+4..T+17;
  - sop at T+4, eop at T+17, done at T+18.
- N=10: last read is bank 2 at addr 1, at T+10; source_3_4 with sample index 6 at T+10; eop at T+13; done at T+14.
- Ignored starts: start with fsm=3'd1; start with len=0; start with len=1793 (wADDR=8); second start during READ. Each -> no extra rden, no extra done; the running frame is unaffected.
- Abort: N=100, fsm leaves 3'd5 at T+20:
  - rden = 0 at T+21;
  - out_valid = 0 from T+21;
  - no eop, no done;
  - a new start then produces a clean frame.
- N=1 and N=3: sop and eop coincide at T+4 for N=1; no source_3_4 pulse for either; done at T+5 and T+7 respectively.
- rst pulsed at T+8 of an N=50 frame: all outputs 0 during reset; after release no activity until the next start; the next frame (N=7) is correct.
